// File: rtl/cam_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cam_ctrl_pkg
// Description : Shared constants and state encoding for the name-CAM
//               front-end controller (cam_lookup_ctrl / name_packer).
//               MAX_CHARS  - characters per name (CAM data width / 8)
//               LEN_W      - width of the length field sent to the CAM
//               ADDR_W     - width of the CAM address / result index
//               CHAR_W     - bits per character
//               LANE_W     - width of a byte-lane index into the CAM word
// Revision    : 1.0 - initial release
// ============================================================================
package cam_ctrl_pkg;

    localparam int MAX_CHARS = 8;
    localparam int LEN_W     = 4;
    localparam int ADDR_W    = 3;
    localparam int CHAR_W    = 8;
    localparam int DATA_W    = MAX_CHARS * CHAR_W;
    localparam int LANE_W    = $clog2(MAX_CHARS);

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        LOOKUP  = 2'd1,
        RESULT  = 2'd2
    } state_t;

endpackage : cam_ctrl_pkg
`default_nettype wire

// File: rtl/cam_lookup_ctrl_name_packer.sv
`default_nettype none
// ============================================================================
// Module      : name_packer
// Description : Packs characters into the CAM data word, one byte lane per
//               character (char k in bits [8k+7:8k]), tracks the stored
//               length and a sticky overflow flag for names that run past
//               MAX_CHARS characters.
//   clk      in   system clock
//   rst_n    in   synchronous active-low reset
//   wr_en    in   store char_in at the next free lane (or flag overflow)
//   clr      in   clear word, length and overflow
//   char_in  in   character to store
//   data     out  packed name, unused lanes zero
//   len      out  number of stored characters
//   ovf      out  a character was dropped because the word was full
// Revision    : 1.0 - initial release
// ============================================================================
module name_packer #(
    parameter int MAX_CHARS = 8,
    parameter int LEN_W     = 4
) (
    input  logic                                     clk,
    input  logic                                     rst_n,
    input  logic                                     wr_en,
    input  logic                                     clr,
    input  logic [cam_ctrl_pkg::CHAR_W-1:0]          char_in,
    output logic [MAX_CHARS*cam_ctrl_pkg::CHAR_W-1:0] data,
    output logic [LEN_W-1:0]                         len,
    output logic                                     ovf
);
    import cam_ctrl_pkg::*;

    logic [LEN_W-1:0] r_count;
    logic             r_ovf;
    logic             w_full;
    logic             w_accept;

    assign w_full   = (r_count == LEN_W'(MAX_CHARS));
    assign w_accept = wr_en & ~w_full;

    // Once full, further characters only set the sticky flag; the count
    // stays at MAX_CHARS so the CAM still sees the truncated word.
    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            r_count <= '0;
            r_ovf   <= 1'b0;
        end else if (wr_en) begin
            if (w_full) begin
                r_ovf <= 1'b1;
            end else begin
                r_count <= r_count + LEN_W'(1);
            end
        end
    end

    for (genvar i = 0; i < MAX_CHARS; i++) begin : g_lane
        logic [CHAR_W-1:0] r_lane;

        always_ff @(posedge clk) begin
            if (!rst_n || clr) begin
                r_lane <= '0;
            end else if (w_accept && (r_count == LEN_W'(i))) begin
                r_lane <= char_in;
            end
        end

        assign data[i*CHAR_W +: CHAR_W] = r_lane;
    end

    assign len = r_count;
    assign ovf = r_ovf;

endmodule : name_packer
`default_nettype wire

// File: rtl/cam_lookup_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : cam_lookup_ctrl
// Description : Front-end controller for the name CAM. Collects an ASCII
//               name over a valid/ready stream, presents the packed word to
//               the external combinational CAM, samples the hit/address one
//               cycle later and holds the result until the consumer takes it.
//   clk, rst_n                 clock, synchronous active-low reset
//   in_valid/in_ready/in_char/in_last   character stream (in_last = final char)
//   cam_data/cam_len           packed name and length to the CAM
//   cam_addr/cam_valid         CAM encoder output and hit flag
//   res_valid/res_ready        result handshake
//   res_hit/res_addr/res_overflow       lookup result
// Revision    : 1.0 - initial release
// ============================================================================
module cam_lookup_ctrl #(
    parameter int MAX_CHARS = 8,
    parameter int LEN_W     = 4,
    parameter int ADDR_W    = 3
) (
    input  logic                                     clk,
    input  logic                                     rst_n,
    input  logic                                     in_valid,
    output logic                                     in_ready,
    input  logic [cam_ctrl_pkg::CHAR_W-1:0]          in_char,
    input  logic                                     in_last,
    output logic [MAX_CHARS*cam_ctrl_pkg::CHAR_W-1:0] cam_data,
    output logic [LEN_W-1:0]                         cam_len,
    input  logic [ADDR_W-1:0]                        cam_addr,
    input  logic                                     cam_valid,
    output logic                                     res_valid,
    input  logic                                     res_ready,
    output logic                                     res_hit,
    output logic [ADDR_W-1:0]                        res_addr,
    output logic                                     res_overflow
);
    import cam_ctrl_pkg::*;

    state_t              r_state;
    logic                r_res_valid;
    logic                r_res_hit;
    logic [ADDR_W-1:0]   r_res_addr;
    logic                r_res_overflow;

    logic                w_ovf;
    logic                w_pack_wr;
    logic                w_pack_clr;
    logic                w_hit;

    // Held low during reset so no character is taken on the reset edge.
    assign in_ready   = rst_n && (r_state == COLLECT);
    assign w_pack_wr  = in_valid & in_ready;
    assign w_pack_clr = (r_state == RESULT) & res_ready;
    assign w_hit      = cam_valid & ~w_ovf;

    name_packer #(
        .MAX_CHARS (MAX_CHARS),
        .LEN_W     (LEN_W)
    ) u_name_packer (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (w_pack_wr),
        .clr     (w_pack_clr),
        .char_in (in_char),
        .data    (cam_data),
        .len     (cam_len),
        .ovf     (w_ovf)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state        <= COLLECT;
            r_res_valid    <= 1'b0;
            r_res_hit      <= 1'b0;
            r_res_addr     <= '0;
            r_res_overflow <= 1'b0;
        end else begin
            case (r_state)
                COLLECT: begin
                    if (w_pack_wr && in_last) begin
                        r_state <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    // The packed word has been stable for a full cycle, so the
                    // CAM's combinational answer is sampled here.
                    r_res_hit      <= w_hit;
                    r_res_addr     <= w_hit ? cam_addr : '0;
                    r_res_overflow <= w_ovf;
                    r_res_valid    <= 1'b1;
                    r_state        <= RESULT;
                end
                RESULT: begin
                    if (res_ready) begin
                        r_res_valid <= 1'b0;
                        r_state     <= COLLECT;
                    end
                end
                default: begin
                    r_state <= COLLECT;
                end
            endcase
        end
    end

    assign res_valid    = r_res_valid;
    assign res_hit      = r_res_hit;
    assign res_addr     = r_res_addr;
    assign res_overflow = r_res_overflow;

endmodule : cam_lookup_ctrl
`default_nettype wire

// File: tb/tb_cam_lookup_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_cam_lookup_ctrl
// Description : Self-checking bench for cam_lookup_ctrl. A small CAM model
//               answers for a fixed table of names; expected results are
//               queued when a name is streamed and compared when the result
//               appears.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cam_lookup_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_char;
    logic        in_last;
    logic [63:0] cam_data;
    logic [3:0]  cam_len;
    logic [2:0]  cam_addr;
    logic        cam_valid;
    logic        res_valid;
    logic        res_ready;
    logic        res_hit;
    logic [2:0]  res_addr;
    logic        res_overflow;

    always #5 clk = ~clk;

    cam_lookup_ctrl #(
        .MAX_CHARS (8),
        .LEN_W     (4),
        .ADDR_W    (3)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_char      (in_char),
        .in_last      (in_last),
        .cam_data     (cam_data),
        .cam_len      (cam_len),
        .cam_addr     (cam_addr),
        .cam_valid    (cam_valid),
        .res_valid    (res_valid),
        .res_ready    (res_ready),
        .res_hit      (res_hit),
        .res_addr     (res_addr),
        .res_overflow (res_overflow)
    );

    // External CAM model: LEO->0, CLAIRE->3, DAVID->4, AARONAAR->5.
    always_comb begin
        cam_valid = 1'b0;
        cam_addr  = 3'd0;
        if (cam_data == 64'h4F454C && cam_len == 4'd3) begin
            cam_valid = 1'b1; cam_addr = 3'd0;
        end else if (cam_data == 64'h455249414C43 && cam_len == 4'd6) begin
            cam_valid = 1'b1; cam_addr = 3'd3;
        end else if (cam_data == 64'h4449564144 && cam_len == 4'd5) begin
            cam_valid = 1'b1; cam_addr = 3'd4;
        end else if (cam_data == 64'h5241414E4F524141 && cam_len == 4'd8) begin
            cam_valid = 1'b1; cam_addr = 3'd5;
        end
    end

    typedef struct {
        logic [63:0] data;
        logic [3:0]  len;
        logic        hit;
        logic [2:0]  addr;
        logic        ovf;
    } exp_t;

    exp_t sb[$];
    int   n_assert = 0;
    int   n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Streams s one character per handshake; in_last on the final one if asked.
    task automatic send_chars(input string s, input bit last_at_end);
        for (int i = 0; i < s.len(); i++) begin
            int guard;
            guard    = 0;
            in_valid = 1'b1;
            in_char  = s[i];
            in_last  = last_at_end && (i == s.len() - 1);
            while (!in_ready && guard < 20) begin
                step();
                guard++;
            end
            if (guard == 20) check($sformatf("%s.handshake_timeout", s), 64'd0, 64'd1);
            step();
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_char  = 8'h00;
    endtask

    task automatic run_name(input string s, input logic [63:0] data, input logic [3:0] len,
                            input logic hit, input logic [2:0] addr, input logic ovf);
        exp_t e;
        e.data = data; e.len = len; e.hit = hit; e.addr = addr; e.ovf = ovf;
        sb.push_back(e);
        send_chars(s, 1'b1);
        // One cycle after the last handshake: LOOKUP, no result yet.
        check($sformatf("%s.lookup_res_valid", s), 64'(res_valid), 64'd0);
        check($sformatf("%s.lookup_in_ready", s), 64'(in_ready), 64'd0);
        step();
        check($sformatf("%s.res_valid_t2", s), 64'(res_valid), 64'd1);
        if (sb.size() == 0) begin
            check($sformatf("%s.scoreboard_empty", s), 64'd0, 64'd1);
        end else begin
            e = sb.pop_front();
            check($sformatf("%s.cam_data", s), cam_data, e.data);
            check($sformatf("%s.cam_len", s), 64'(cam_len), 64'(e.len));
            check($sformatf("%s.res_hit", s), 64'(res_hit), 64'(e.hit));
            check($sformatf("%s.res_addr", s), 64'(res_addr), 64'(e.addr));
            check($sformatf("%s.res_overflow", s), 64'(res_overflow), 64'(e.ovf));
        end
    endtask

    task automatic release_result(input string tag);
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        check($sformatf("%s.rel_res_valid", tag), 64'(res_valid), 64'd0);
        check($sformatf("%s.rel_in_ready", tag), 64'(in_ready), 64'd1);
        check($sformatf("%s.rel_cam_data", tag), cam_data, 64'd0);
        check($sformatf("%s.rel_cam_len", tag), 64'(cam_len), 64'd0);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_char   = 8'h00;
        in_last   = 1'b0;
        res_ready = 1'b0;
        step();
        step();
        check("rst.cam_data", cam_data, 64'd0);
        check("rst.cam_len", 64'(cam_len), 64'd0);
        check("rst.res_valid", 64'(res_valid), 64'd0);
        check("rst.res_hit", 64'(res_hit), 64'd0);
        check("rst.res_addr", 64'(res_addr), 64'd0);
        check("rst.res_overflow", 64'(res_overflow), 64'd0);
        check("rst.in_ready_low", 64'(in_ready), 64'd0);
        rst_n = 1'b1;
        #1;
        check("rst.in_ready_high", 64'(in_ready), 64'd1);

        run_name("LEO", 64'h4F454C, 4'd3, 1'b1, 3'd0, 1'b0);
        release_result("LEO");

        run_name("CLAIRE", 64'h455249414C43, 4'd6, 1'b1, 3'd3, 1'b0);
        release_result("CLAIRE");

        run_name("BOB", 64'h424F42, 4'd3, 1'b0, 3'd0, 1'b0);
        release_result("BOB");

        // Ninth character dropped; CAM model still hits on the truncated word.
        run_name("AARONAARO", 64'h5241414E4F524141, 4'd8, 1'b0, 3'd0, 1'b1);
        check("ovf.cam_valid_model", 64'(cam_valid), 64'd1);

        // Consumer stalls while the source keeps offering a character.
        in_valid = 1'b1;
        in_char  = "X";
        for (int k = 0; k < 5; k++) begin
            step();
            check($sformatf("hold%0d.in_ready", k), 64'(in_ready), 64'd0);
            check($sformatf("hold%0d.res_valid", k), 64'(res_valid), 64'd1);
            check($sformatf("hold%0d.res_overflow", k), 64'(res_overflow), 64'd1);
            check($sformatf("hold%0d.res_hit", k), 64'(res_hit), 64'd0);
            check($sformatf("hold%0d.cam_len", k), 64'(cam_len), 64'd8);
            check($sformatf("hold%0d.cam_data", k), cam_data, 64'h5241414E4F524141);
        end
        in_valid = 1'b0;
        in_char  = 8'h00;
        release_result("hold");

        // Reset in the middle of a name discards the partial word.
        send_chars("DA", 1'b0);
        check("partial.cam_len", 64'(cam_len), 64'd2);
        check("partial.cam_data", cam_data, 64'h4144);
        rst_n = 1'b0;
        step();
        check("midrst.cam_len", 64'(cam_len), 64'd0);
        check("midrst.cam_data", cam_data, 64'd0);
        check("midrst.res_valid", 64'(res_valid), 64'd0);
        check("midrst.in_ready", 64'(in_ready), 64'd0);
        rst_n = 1'b1;
        #1;
        check("midrst.in_ready_after", 64'(in_ready), 64'd1);

        run_name("DAVID", 64'h4449564144, 4'd5, 1'b1, 3'd4, 1'b0);
        release_result("DAVID");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule : tb_cam_lookup_ctrl
`default_nettype wire
